// File: rtl/mskunmask_ser_pkg.sv
// rtl/mskunmask_ser_pkg.sv - shared state encodings and counter width for the serial unmasker
package mskunmask_ser_pkg;

    // Binary state encoding, shared by every file of the unmasker.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    // Share counter width: indexes shares 0..n-1 without wrapping.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mskunmask_ser_shbank.sv
// rtl/mskunmask_ser_shbank.sv - share storage with bulk load and per-slot clear
module mskunmask_ser_shbank
    import mskunmask_ser_pkg::*;
#(
    parameter int d = 2,
    parameter int w = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [d*w-1:0]          in_sh,
    input  logic                    clr_en,
    input  logic [cnt_width(d)-1:0] idx,
    output logic [w-1:0]            rd_data
);

    logic [w-1:0] slot [d];

    // Load all shares at once (slot 0 is consumed on load so it stays clear);
    // otherwise wipe the slot that is being read this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < d; i++) begin
                slot[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < d; i++) begin
                slot[i] <= (i == 0) ? '0 : in_sh[i*w +: w];
            end
        end else if (clr_en) begin
            slot[idx] <= '0;
        end
    end

    // Exactly one share leaves the bank per cycle; no share-to-share mixing here.
    assign rd_data = slot[idx];

endmodule

// File: rtl/mskunmask_ser.sv
// rtl/mskunmask_ser.sv - serial unmasker: XORs d shares one per cycle into an unmasked value
module mskunmask_ser
    import mskunmask_ser_pkg::*;
#(
    parameter int d = 2,
    parameter int w = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    (* fv_type = "sharing" *)  input  logic [d*w-1:0] in_sh,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    (* fv_type = "unmasked" *) output logic [w-1:0]   out_data,
    output logic                                    busy
);

    localparam int CW = cnt_width(d);

    generate
        if (d < 2 || d > 16) begin : g_bad_d
            $error("mskunmask_ser: parameter d must lie in 2..16");
        end
    endgenerate

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [w-1:0]  acc;
    logic [w-1:0]  bank_rd;
    logic          accept;
    logic          last;

    assign accept = (state == ST_IDLE) && in_valid;
    assign last   = (cnt == CW'(d - 1));

    (* keep = "true", dont_touch = "true" *)
    mskunmask_ser_shbank #(
        .d (d),
        .w (w)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .in_sh   (in_sh),
        .clr_en  (state == ST_ACC),
        .idx     (cnt),
        .rd_data (bank_rd)
    );

    // Control FSM and accumulator: share 0 seeds acc directly, then one bank share per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        acc   <= in_sh[w-1:0];
                        cnt   <= CW'(1);
                        state <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    acc <= acc ^ bank_rd;
                    if (last) begin
                        state <= ST_OUT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    acc   <= '0;
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshakes decode registered state only; acc is masked so partial sums never leak.
    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_OUT);
    assign out_data  = out_valid ? acc : '0;

endmodule

// File: tb/tb_mskunmask_ser.sv
// tb/tb_mskunmask_ser.sv - scoreboard bench for mskunmask_ser (d=3/w=4 and d=2/w=1)
module tb_mskunmask_ser;

    typedef struct {
        logic [3:0] data;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic started = 1'b0;

    exp_t q_a[$];
    exp_t q_b[$];

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [11:0] a_in_sh;
    logic [3:0]  a_out_data;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [1:0]  b_in_sh;
    logic [0:0]  b_out_data;

    always #5 clk = ~clk;

    // Cycle index: value between two rising edges.
    always @(posedge clk) cyc <= cyc + 1;

    mskunmask_ser #(.d(3), .w(4)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sh(a_in_sh),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .busy(a_busy)
    );

    mskunmask_ser #(.d(2), .w(1)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sh(b_in_sh),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .busy(b_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_acc"}, 32'(dut_a.acc), 0);
        for (int i = 0; i < 3; i++) chk({tag, "_slot"}, 32'(dut_a.u_bank.slot[i]), 0);
    endtask

    task automatic chk_zero_b(input string tag);
        chk({tag, "_acc"}, 32'(dut_b.acc), 0);
        for (int i = 0; i < 2; i++) chk({tag, "_slot"}, 32'(dut_b.u_bank.slot[i]), 0);
    endtask

    // Monitor: on every output handshake pop the expected value and its cycle.
    always @(negedge clk) begin
        if (started) begin
            if (a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
                if (q_a.size() == 0) begin
                    chk("a_unexpected_out", 1, 0);
                end else begin
                    exp_t e;
                    e = q_a.pop_front();
                    chk("a_out_data", 32'(a_out_data), 32'(e.data));
                    chk("a_out_cycle", cyc, e.cyc);
                end
            end else if (a_out_valid !== 1'b1) begin
                chk("a_data_zero_when_invalid", 32'(a_out_data), 0);
            end
            if (b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
                if (q_b.size() == 0) begin
                    chk("b_unexpected_out", 1, 0);
                end else begin
                    exp_t e;
                    e = q_b.pop_front();
                    chk("b_out_data", 32'(b_out_data), 32'(e.data));
                    chk("b_out_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_sh = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_sh = '0; b_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        started = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_a_in_ready", 32'(a_in_ready), 1);
        chk("rst_a_out_valid", 32'(a_out_valid), 0);
        chk("rst_a_out_data", 32'(a_out_data), 0);
        chk("rst_a_busy", 32'(a_busy), 0);
        chk("rst_b_in_ready", 32'(b_in_ready), 1);
        chk("rst_b_busy", 32'(b_busy), 0);
        chk_zero_a("rst_a");
        next();

        // d=3: shares 5,A,3 -> C after 3 cycles; in_sh churn during ACC is ignored
        a_in_valid = 1'b1; a_in_sh = 12'h3A5; k = cyc;
        q_a.push_back('{4'hC, k + 3});
        @(negedge clk);
        chk("a1_in_ready_accept", 32'(a_in_ready), 1);
        next();
        a_in_valid = 1'b0; a_in_sh = 12'hFFF;
        @(negedge clk);
        chk("a1_no_valid_c1", 32'(a_out_valid), 0);
        chk("a1_busy_c1", 32'(a_busy), 1);
        next();
        a_in_sh = 12'h123;
        @(negedge clk);
        chk("a1_no_valid_c2", 32'(a_out_valid), 0);
        next();
        @(negedge clk);
        chk("a1_valid_c3", 32'(a_out_valid), 1);
        next();
        @(negedge clk);
        chk("a1_in_ready_after", 32'(a_in_ready), 1);
        chk("a1_busy_after", 32'(a_busy), 0);
        chk_zero_a("a1_zero");
        next();

        // d=3 with out_ready low for 5 cycles; new in_valid during OUT is ignored
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_sh = 12'h3A5; k = cyc;
        q_a.push_back('{4'hC, k + 8});
        next();
        a_in_valid = 1'b0;
        next();
        next();
        a_in_valid = 1'b1; a_in_sh = 12'h777;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("a2_hold_valid", 32'(a_out_valid), 1);
            chk("a2_hold_data", 32'(a_out_data), 32'hC);
            chk("a2_hold_in_ready", 32'(a_in_ready), 0);
            chk("a2_hold_busy", 32'(a_busy), 1);
            next();
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        next();
        @(negedge clk);
        chk("a2_idle_in_ready", 32'(a_in_ready), 1);
        chk("a2_idle_busy", 32'(a_busy), 0);
        chk_zero_a("a2_zero");
        next();

        // Reset one cycle after acceptance abandons the transaction
        a_in_valid = 1'b1; a_in_sh = 12'h71F;
        next();
        a_in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("a3_busy_in_acc", 32'(a_busy), 1);
        next();
        rst = 1'b0;
        @(negedge clk);
        chk("a3_in_ready", 32'(a_in_ready), 1);
        chk("a3_busy", 32'(a_busy), 0);
        chk_zero_a("a3_zero");
        for (int i = 0; i < 3; i++) begin
            next();
            @(negedge clk);
            chk("a3_no_out_valid", 32'(a_out_valid), 0);
        end
        next();

        // Reset wins over a simultaneous acceptance
        a_in_valid = 1'b1; a_in_sh = 12'h5A5; rst = 1'b1;
        next();
        a_in_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("a4_rst_priority_busy", 32'(a_busy), 0);
        chk_zero_a("a4_zero");
        next();

        // Reset while held in OUT drops the result
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_sh = 12'h3A5;
        next();
        a_in_valid = 1'b0;
        next();
        next();
        @(negedge clk);
        chk("a5_in_out", 32'(a_out_valid), 1);
        rst = 1'b1;
        next();
        rst = 1'b0; a_out_ready = 1'b1;
        @(negedge clk);
        chk("a5_dropped", 32'(a_out_valid), 0);
        chk("a5_in_ready", 32'(a_in_ready), 1);
        chk_zero_a("a5_zero");
        next();

        // d=2: back-to-back with in_valid held; (1,1)->0 then (1,0)->1, 3 cycles apart
        b_in_valid = 1'b1; b_in_sh = 2'b11; k = cyc;
        q_b.push_back('{4'h0, k + 2});
        q_b.push_back('{4'h1, k + 5});
        @(negedge clk);
        chk("b_ready_k", 32'(b_in_ready), 1);
        next();
        b_in_sh = 2'b01;
        @(negedge clk);
        chk("b_ready_k1", 32'(b_in_ready), 0);
        next();
        @(negedge clk);
        chk("b_ready_k2", 32'(b_in_ready), 0);
        next();
        @(negedge clk);
        chk("b_ready_k3", 32'(b_in_ready), 1);
        next();
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("b_ready_k4", 32'(b_in_ready), 0);
        next();
        next();
        @(negedge clk);
        chk("b_ready_k6", 32'(b_in_ready), 1);
        chk_zero_b("b_zero");

        repeat (3) next();
        chk("a_scoreboard_drained", q_a.size(), 0);
        chk("b_scoreboard_drained", q_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mskunmask_ser.md
MSKUNMASK_SER -- requirements
Module: MSKunmask_ser

Interface
REQ-001 Parameter d, default 2: number of shares; legal range 2..16, elaboration error otherwise.
REQ-002 Parameter w, default 1: bits per share.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  sharing available on in_sh.
REQ-006 in_ready  output  1  block can accept a sharing.
REQ-007 in_sh  input  d*w  d shares; share i occupies bits [i*w +: w].
REQ-008 out_valid  output  1  unmasked value available.
REQ-009 out_ready  input  1  consumer takes the value.
REQ-010 out_data  output  w  unmasked value, XOR of all d shares.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, ACC and OUT, with one-hot or binary encoding fixed in the include file.
REQ-013 in_ready SHALL equal (state==IDLE), decoded from registered state only.
REQ-014 On in_valid&&in_ready: latch all d shares into the share bank; acc<=share0; share0 slot<=0; cnt<=1; state<=ACC.
REQ-015 In ACC, each cycle: acc<=acc^share[cnt]; share[cnt] slot<=0; cnt<=cnt+1.
REQ-016 The block SHALL combine exactly one share per cycle; no combinational XOR of two or more input shares is permitted (glitch isolation).
REQ-017 When cnt==d-1 in ACC, the block SHALL perform the final XOR and set state<=OUT.
REQ-018 Latency: if acceptance occurs in cycle k, out_valid SHALL first be high in cycle k+d.
REQ-019 In OUT: out_valid=1 and out_data=acc, held stable until out_ready.
REQ-020 On out_valid&&out_ready: acc<=0, cnt<=0, state<=IDLE; in_ready SHALL rise the following cycle (no same-cycle bypass).
REQ-021 Maximum throughput SHALL be one sharing per d+1 cycles.
REQ-022 out_data SHALL be forced to 0 whenever out_valid is low, so partial accumulations are never visible.
REQ-023 in_valid and in_sh SHALL be ignored outside IDLE.
REQ-024 cnt width SHALL be $clog2(d) and SHALL NOT wrap within a transaction.
REQ-025 After a transaction, all share-bank slots and acc SHALL be zero (zeroization).

Reset
REQ-026 rst SHALL set state=IDLE, cnt=0, acc=0 and all share-bank slots to 0, giving in_ready=1, out_valid=0, out_data=0 and busy=0 in the next cycle.
REQ-027 rst asserted mid-transaction (ACC or OUT) SHALL abandon the transaction with no out_valid pulse.
REQ-028 rst SHALL take priority over any simultaneous handshake.

Structure
REQ-029 State encodings and the cnt width function SHALL reside in shared include MSKunmask_ser.inc.
REQ-030 The share storage with per-slot clear SHALL be one sub-module, MSKunmask_shbank (parameters d, w), kept with preserve/keep attributes.
REQ-031 in_sh SHALL carry fv_type="sharing"; out_data SHALL be annotated as an unmasked (non-sharing) output.

Verification
REQ-032 d=3, w=4, shares 0x5,0xA,0x3 accepted in cycle 0 -> out_valid first in cycle 3, out_data=0xC; out_data=0 in cycles 1-2.
REQ-033 Same case with out_ready low for 5 cycles -> out_data held at 0xC, in_ready=0 and busy=1 throughout; IDLE one cycle after out_ready=1.
REQ-034 d=2, w=1, out_ready tied 1, in_valid held with (1,1) then (1,0) -> outputs 0 then 1; acceptances spaced exactly 3 cycles apart.
REQ-035 rst pulsed in cycle k+1 after acceptance -> no out_valid; next cycle in_ready=1 and acc and all share slots are 0.
REQ-036 After any completed transaction, hierarchical check shows share bank and acc all zero; in_sh changes during ACC do not affect out_data.
